// File: rtl/pipelined_shifter.sv
// Pipelined shift/rotate unit with a valid/ready handshake at both ends.
// The log-shifter levels are split across STAGES register stages. Each
// stage accepts new data when it is empty or when its contents move on
// downstream, so empty stages (bubbles) are filled straight away.
module pipelined_shifter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [2:0]            in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result
);

    localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
    localparam int unsigned LAST    = STAGES - 1;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    // Contents of one pipeline stage apart from its valid bit
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [SHAMT_W-1:0]    sh;
        logic [2:0]            op;
        logic                  sign;
    } stage_t;

    // Returns the pipeline stage that holds log-shifter level k
    function automatic int unsigned level_stage(input int unsigned k);
        return (k * STAGES) / SHAMT_W;
    endfunction

    // One log-shifter level: shift or rotate d by 2^k. Unknown opcodes
    // pass d through unchanged.
    function automatic logic [DATA_WIDTH-1:0] shift_level(
        input logic [DATA_WIDTH-1:0] d,
        input logic [2:0]            op,
        input logic                  sign,
        input int unsigned           k
    );
        logic [2*DATA_WIDTH-1:0] ext;
        int unsigned             amt;
        amt = 32'd1 << k;
        ext = {{DATA_WIDTH{sign}}, d} >> amt;
        case (op)
            OP_SLL:  return d << amt;
            OP_SRL:  return d >> amt;
            OP_SRA:  return ext[DATA_WIDTH-1:0];
            OP_ROL:  return (d << amt) | (d >> (DATA_WIDTH - amt));
            OP_ROR:  return (d >> amt) | (d << (DATA_WIDTH - amt));
            default: return d;
        endcase
    endfunction

    logic   [STAGES-1:0] valid_q;
    logic   [STAGES-1:0] valid_d;
    logic   [STAGES-1:0] load;
    stage_t [STAGES-1:0] stage_q;
    stage_t [STAGES-1:0] stage_d;

    // A stage may load when it is empty or when some later stage (or the
    // consumer) has room. This is the only path from out_ready to in_ready.
    always_comb begin
        logic room;
        room = out_ready;
        load = '0;
        for (int s = int'(STAGES) - 1; s >= 0; s--) begin
            room    = room | ~valid_q[s];
            load[s] = room;
        end
    end

    for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
        localparam int unsigned STAGE_IDX = s;

        stage_t                src;
        logic                  src_valid;
        logic [DATA_WIDTH-1:0] lvl;

        if (s == 0) begin : g_in
            assign src_valid = in_valid;
            assign src       = '{data: in_a, sh: in_b[SHAMT_W-1:0],
                                 op: in_op, sign: in_a[DATA_WIDTH-1]};
        end else begin : g_chain
            assign src_valid = valid_q[s-1];
            assign src       = stage_q[s-1];
        end

        // Apply the levels that belong to this stage
        always_comb begin
            lvl = src.data;
            for (int unsigned k = 0; k < SHAMT_W; k++) begin
                if (level_stage(k) == STAGE_IDX && src.sh[k]) begin
                    lvl = shift_level(lvl, src.op, src.sign, k);
                end
            end
        end

        assign valid_d[s] = src_valid;
        assign stage_d[s] = '{data: lvl, sh: src.sh, op: src.op, sign: src.sign};
    end

    // Stage registers; payload only updates when a valid op moves in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            stage_q <= '0;
        end else begin
            for (int s = 0; s < int'(STAGES); s++) begin
                if (load[s]) begin
                    valid_q[s] <= valid_d[s];
                    if (valid_d[s]) begin
                        stage_q[s] <= stage_d[s];
                    end
                end
            end
        end
    end

    assign in_ready   = load[0];
    assign out_valid  = valid_q[LAST];
    assign out_result = stage_q[LAST].data;

    // Upper shift-amount bits and the last stage's control fields are
    // intentionally left unused
    logic unused_bits;
    assign unused_bits = ^{in_b[DATA_WIDTH-1:SHAMT_W], stage_q[LAST].sh,
                           stage_q[LAST].op, stage_q[LAST].sign};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter: three instances (STAGES = 2, 1, 5)
// with their own handshake signals, driven one at a time.
module tb_pipelined_shifter;

    localparam int unsigned W = 32;
    localparam int          N = 3;

    logic         clk;
    logic         rst;
    logic         in_valid   [N];
    logic         in_ready   [N];
    logic         out_valid  [N];
    logic         out_ready  [N];
    logic [W-1:0] in_a       [N];
    logic [W-1:0] in_b       [N];
    logic [W-1:0] out_result [N];
    logic [2:0]   in_op      [N];

    int tests;
    int fails;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [19] = '{
        '{3'b011, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF},
        '{3'b010, 32'h8000_0000, 32'd31,        32'h0000_0001},
        '{3'b000, 32'h0000_0001, 32'd31,        32'h8000_0000},
        '{3'b101, 32'h1234_5678, 32'd8,         32'h7812_3456},
        '{3'b100, 32'h1234_5678, 32'd4,         32'h2345_6781},
        '{3'b001, 32'h1234_5678, 32'd5,         32'h1234_5678},
        '{3'b000, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002},
        '{3'b110, 32'hCAFE_F00D, 32'd3,         32'hCAFE_F00D},
        '{3'b111, 32'hCAFE_F00D, 32'd3,         32'hCAFE_F00D},
        '{3'b011, 32'h7000_0000, 32'd4,         32'h0700_0000},
        '{3'b011, 32'hF000_0000, 32'hFFFF_FFE4, 32'hFF00_0000},
        '{3'b100, 32'h8000_0001, 32'd1,         32'h0000_0003},
        '{3'b101, 32'h0000_0001, 32'd31,        32'h0000_0002},
        '{3'b000, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF},
        '{3'b010, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF},
        '{3'b011, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF},
        '{3'b100, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF},
        '{3'b101, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF},
        '{3'b010, 32'hF0F0_0000, 32'd19,        32'h0000_1E1E}
    };

    // Back-to-back stimulus and the results worked out by hand
    vec_t b2b [4] = '{
        '{3'b000, 32'h0000_0001, 32'd3, 32'h0000_0008},
        '{3'b010, 32'h0000_0080, 32'd4, 32'h0000_0008},
        '{3'b101, 32'h0000_000F, 32'd4, 32'hF000_0000},
        '{3'b011, 32'h8000_0000, 32'd1, 32'hC000_0000}
    };

    pipelined_shifter #(.DATA_WIDTH(W), .STAGES(2)) u_s2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_op(in_op[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_result(out_result[0])
    );

    pipelined_shifter #(.DATA_WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_op(in_op[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_result(out_result[1])
    );

    pipelined_shifter #(.DATA_WIDTH(W), .STAGES(5)) u_s5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a[2]), .in_b(in_b[2]), .in_op(in_op[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_result(out_result[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int stages_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    // Offer one op to DUT i, then wait (bounded) for its result.
    // lat counts edges from the accepting edge (1) to the first edge
    // after which out_valid is seen; -1 means it never arrived.
    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, output logic [W-1:0] res, output int lat);
        @(negedge clk);
        in_a[i] = a; in_b[i] = b; in_op[i] = op;
        in_valid[i]  = 1'b1;
        out_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        lat = -1;
        res = '0;
        for (int c = 1; c <= 20; c++) begin
            if (out_valid[i]) begin
                lat = c;
                res = out_result[i];
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            tests++;
            if (out_valid[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset_out_valid dut%0d: got %b want 0", i, out_valid[i]);
            end
            tests++;
            if (out_result[i] !== '0) begin
                fails++;
                $display("FAIL reset_out_result dut%0d: got %h want 0", i, out_result[i]);
            end
            tests++;
            if (in_ready[i] !== 1'b1) begin
                fails++;
                $display("FAIL reset_in_ready dut%0d: got %b want 1", i, in_ready[i]);
            end
        end
    endtask

    task automatic test_shift_ops();
        logic [W-1:0] res;
        int           lat;
        for (int i = 0; i < N; i++) begin
            for (int v = 0; v < 19; v++) begin
                issue(i, vecs[v].a, vecs[v].b, vecs[v].op, res, lat);
                tests++;
                if (lat !== stages_of(i)) begin
                    fails++;
                    $display("FAIL shift_latency dut%0d vec%0d: got %0d want %0d",
                             i, v, lat, stages_of(i));
                end
                tests++;
                if (res !== vecs[v].exp) begin
                    fails++;
                    $display("FAIL shift_result dut%0d vec%0d: got %h want %h",
                             i, v, res, vecs[v].exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got_v [4];
        int           got_c [4];
        int           got_n;
        int           s;
        for (int i = 0; i < N; i++) begin
            s     = stages_of(i);
            got_n = 0;
            for (int c = 0; c < s + 8; c++) begin
                @(negedge clk);
                out_ready[i] = 1'b1;
                if (c < 4) begin
                    in_a[i] = b2b[c].a; in_b[i] = b2b[c].b; in_op[i] = b2b[c].op;
                    in_valid[i] = 1'b1;
                end else begin
                    in_valid[i] = 1'b0;
                end
                #1;
                if (c < 4) begin
                    tests++;
                    if (in_ready[i] !== 1'b1) begin
                        fails++;
                        $display("FAIL b2b_in_ready dut%0d cycle%0d: got %b want 1",
                                 i, c, in_ready[i]);
                    end
                end
                @(posedge clk);
                #1;
                if (out_valid[i]) begin
                    if (got_n < 4) begin
                        got_v[got_n] = out_result[i];
                        got_c[got_n] = c;
                    end
                    got_n++;
                end
            end
            in_valid[i] = 1'b0;
            tests++;
            if (got_n != 4) begin
                fails++;
                $display("FAIL b2b_count dut%0d: got %0d want 4", i, got_n);
            end
            for (int j = 0; j < 4 && j < got_n; j++) begin
                tests++;
                if (got_c[j] != j + s - 1) begin
                    fails++;
                    $display("FAIL b2b_cycle dut%0d res%0d: got %0d want %0d",
                             i, j, got_c[j], j + s - 1);
                end
                tests++;
                if (got_v[j] !== b2b[j].exp) begin
                    fails++;
                    $display("FAIL b2b_result dut%0d res%0d: got %h want %h",
                             i, j, got_v[j], b2b[j].exp);
                end
            end
        end
    endtask

    // Stall the consumer, fill the pipe, then drain while accepting one
    // more op on the first draining edge. Op j is SLL 1 by j -> 1 << j.
    task automatic test_backpressure();
        int   s;
        int   acc;
        int   n;
        logic take;
        for (int i = 0; i < N; i++) begin
            s   = stages_of(i);
            acc = 0;
            for (int c = 0; c < s + 4; c++) begin
                @(negedge clk);
                out_ready[i] = 1'b0;
                in_valid[i]  = 1'b1;
                in_a[i] = 32'h1; in_b[i] = W'(acc); in_op[i] = 3'b000;
                #1;
                tests++;
                if (in_ready[i] !== (acc < s)) begin
                    fails++;
                    $display("FAIL bp_in_ready dut%0d cycle%0d: got %b want %b",
                             i, c, in_ready[i], (acc < s));
                end
                if (c >= s) begin
                    tests++;
                    if (out_valid[i] !== 1'b1 || out_result[i] !== 32'h1) begin
                        fails++;
                        $display("FAIL bp_hold dut%0d cycle%0d: got v=%b %h want v=1 00000001",
                                 i, c, out_valid[i], out_result[i]);
                    end
                end
                take = in_ready[i];
                @(posedge clk);
                if (take === 1'b1) acc++;
            end
            tests++;
            if (acc != s) begin
                fails++;
                $display("FAIL bp_accepts dut%0d: got %0d want %0d", i, acc, s);
            end
            n = 0;
            for (int c = 0; c < s + 10; c++) begin
                @(negedge clk);
                out_ready[i] = 1'b1;
                in_valid[i]  = (c == 0);
                in_b[i]      = W'(s);
                #1;
                take = 1'b0;
                if (c == 0) begin
                    tests++;
                    if (in_ready[i] !== 1'b1) begin
                        fails++;
                        $display("FAIL bp_full_accept dut%0d: got %b want 1", i, in_ready[i]);
                    end
                    take = in_ready[i];
                end
                if (out_valid[i]) begin
                    tests++;
                    if (out_result[i] !== (32'd1 << n)) begin
                        fails++;
                        $display("FAIL bp_drain dut%0d res%0d: got %h want %h",
                                 i, n, out_result[i], 32'd1 << n);
                    end
                    n++;
                end
                @(posedge clk);
                if (take === 1'b1) acc++;
            end
            in_valid[i] = 1'b0;
            #1;
            tests++;
            if (n != s + 1) begin
                fails++;
                $display("FAIL bp_drain_count dut%0d: got %0d want %0d", i, n, s + 1);
            end
            tests++;
            if (out_valid[i] !== 1'b0) begin
                fails++;
                $display("FAIL bp_empty dut%0d: got %b want 0", i, out_valid[i]);
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic [W-1:0] res;
        int           lat;
        @(negedge clk);
        out_ready[0] = 1'b0;
        in_a[0] = 32'h1; in_b[0] = 32'd1; in_op[0] = 3'b000;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_a[0] = 32'h3; in_b[0] = 32'd2;
        @(negedge clk);
        in_valid[0] = 1'b0;
        tests++;
        if (out_valid[0] !== 1'b1) begin
            fails++;
            $display("FAIL inflight_setup: got out_valid %b want 1", out_valid[0]);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (out_valid[0] !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_valid: got %b want 0", out_valid[0]);
        end
        tests++;
        if (out_result[0] !== '0) begin
            fails++;
            $display("FAIL async_reset_result: got %h want 0", out_result[0]);
        end
        tests++;
        if (in_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL async_reset_ready: got %b want 1", in_ready[0]);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid[0] !== 1'b0) begin
                fails++;
                $display("FAIL stale_result cycle%0d: got out_valid %b want 0", c, out_valid[0]);
            end
        end
        issue(0, 32'hA5A5_A5A5, 32'd4, 3'b101, res, lat);
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL post_reset_latency: got %0d want 2", lat);
        end
        tests++;
        if (res !== 32'h5A5A_5A5A) begin
            fails++;
            $display("FAIL post_reset_result: got %h want 5a5a5a5a", res);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < N; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            in_a[i]      = '0;
            in_b[i]      = '0;
            in_op[i]     = '0;
        end
        test_reset();
        test_shift_ops();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the combinational ALU shifter.
- Adds configurable data width, configurable pipeline depth, rotate modes, and a valid/ready handshake with backpressure.
- Intended for the datapath and the DNN accelerator, where multi-cycle shift/rotate ops must not limit clock frequency.
- One result per cycle at full throughput; fixed latency of STAGES cycles.

Parameters:
- DATA_WIDTH, 32: operand/result width; power of two, 8..64.
- STAGES, 2: number of register stages, 1..log2(DATA_WIDTH).
- SHAMT_W (localparam): log2(DATA_WIDTH); number of shift-amount bits used.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: operation offered.
- in_ready, output, 1: block can accept an operation this cycle.
- in_a, input, DATA_WIDTH: operand to shift.
- in_b, input, DATA_WIDTH: shift amount; only in_b[SHAMT_W-1:0] is used.
- in_op, input, 3: operation code.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- out_result, output, DATA_WIDTH: shifted value.

Behaviour:
- Opcodes:
  - 000 SLL, 010 SRL, 011 SRA (sign fill from in_a[MSB]).
  - 100 ROL, 101 ROR.
  - 001, 110, 111 PASS: out_result = in_a.
  - 2-bit legacy codes {0,op} keep their old meaning.
- Shift amount: sh = in_b[SHAMT_W-1:0]; upper bits of in_b are ignored (MIPS semantics). sh = 0 returns in_a for every op.
- Log-shifter levels:
  - Level k shifts by 2^k when sh[k] = 1, for k = 0..SHAMT_W-1.
  - Level k is placed in stage s = floor(k*STAGES/SHAMT_W).
  - Each stage ends in a register holding {valid, data, remaining sh bits, op, sign bit}.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - Stage s advances when its successor is empty or advancing.
  - The last stage advances when out_ready is high.
  - Bubbles collapse: an empty stage always accepts.
  - in_ready = stage 0 empty OR stage 0 advancing. It is combinational from out_ready through the valid chain; no ready→valid combinational path.
- Latency: a transfer accepted at edge N appears with out_valid = 1 after edge N+STAGES-1 when there is no stall. With STAGES = 1, the result is registered on the accepting edge.
- Throughput: 1 op/cycle while out_ready = 1. With out_ready = 0, up to STAGES ops are buffered, then in_ready = 0.
- Stability: while out_valid && !out_ready, out_result holds constant. No drop, duplicate or reorder of results; order is strictly FIFO.
- Simultaneous accept and emit when full: allowed; the pipeline shifts by one.
- Reset:
  - All stage valids go to 0 immediately on rst assertion, including mid-operation. Outputs: out_valid = 0, out_result = 0, in_ready = 1 after reset.
  - In-flight ops are discarded.
  - Data registers reset to 0.
- Input values are sampled only on transfer; in_a/in_b/in_op are don't-care otherwise.

Test Plan (DATA_WIDTH = 32, STAGES = 2 unless noted):
1. SRA a = 0x80000000, b = 31 → 0xFFFFFFFF. SRL with the same operands → 0x00000001. SLL a = 0x00000001, b = 31 → 0x80000000.
2. ROR a = 0x12345678, b = 8 → 0x78123456. ROL a = 0x12345678, b = 4 → 0x23456781. PASS (op = 001), b = 5 → 0x12345678.
3. SLL a = 0x00000001, b = 0x00000021 → 0x00000002 (only b[4:0] = 1 is used). Any op with b = 0 returns a.
4. Throughput: 4 back-to-back ops accepted on edges 0..3 with out_ready = 1 → out_valid on cycles 1..4 (first edge after N+1), results in order.
5. Backpressure: out_ready = 0 for 5 cycles while in_valid = 1 → in_ready goes low after 2 accepts, and out_result holds stable. Raising out_ready then drains all results once, in order; repeat with STAGES = 1 and STAGES = 5.
6. Reset: assert rst asynchronously (mid-cycle) with 2 ops in flight → out_valid falls before the next edge and in_ready = 1. After rst is released, a new op completes normally with correct latency and no stale result appears.
